apb_slave: RTL and testbench
============================

# apb_slave

APB completer that terminates transfers issued by the team's `apb_master`. It decodes `pselx`/`penable`/`pwrite`, backs the address space with a word-addressed register memory, and returns `prdata`, `pready` and `pslverr`. Optional wait-state insertion lets the bench exercise the master's `pready` stall path. It sits on the same APB segment as `apb_master`, one completer per `pselx`.

## Interface

**Parameters**
- `ADDR_WIDTH`, 10: `paddr` width, in word-address units.
- `DATA_WIDTH`, 32: `pwdata`/`prdata` width.
- `MEM_DEPTH`, 256: number of implemented words, valid range 1..2^`ADDR_WIDTH`.
- `WAIT_CYCLES`, 2: wait states per transfer, range 0..15. Used only with `APB_SLAVE_WAIT_EN`.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `pselx`, input, 1: completer select.
- `penable`, input, 1: access-phase indicator.
- `pwrite`, input, 1: 1 = write, 0 = read.
- `paddr`, input, `ADDR_WIDTH`: word address.
- `pwdata`, input, `DATA_WIDTH`: write data.
- `prdata`, output, `DATA_WIDTH`: read data; reset value 0.
- `pready`, output, 1: transfer completes this cycle; reset value 0.
- `pslverr`, output, 1: error response, valid only while `pready`=1; reset value 0.

## Operation

**FSM states:** `IDLE` and `ACCESS`. Reset value is `IDLE`.

**IDLE**
- On an edge with `pselx`=1 and `penable`=0 (setup phase), capture `paddr`, `pwrite` and `pwdata`, and go to `ACCESS`.
- At the same edge:
  - Load the wait counter with `WAIT_CYCLES` (or 0 when the macro is off).
  - Register `err` = (`paddr` >= `MEM_DEPTH`).
  - For reads, register `prdata` = mem[`paddr`], or 0 if `err`.
- `penable`=1 while in `IDLE` (no preceding setup phase) is ignored and `pready` stays 0.

**ACCESS**
- `pready` is decoded from registers: (state == `ACCESS`) && (counter == 0).
- `pslverr` = `pready` && `err`.
- When the counter is nonzero and `penable`=1, it decrements by 1 per cycle.
- **Completion edge** (`pselx` && `penable` && `pready`):
  - For a write with `err`=0, commit mem[captured addr] = captured `pwdata`.
  - Go to `IDLE` unconditionally.
- **Abort:** `pselx`=0 in `ACCESS` → go to `IDLE`, no write, `pready` 0 in the following cycle.

**Error handling**
- Out-of-range writes are dropped.
- Out-of-range reads return 0.
- Both complete normally with `pslverr`=1.

**Reset**
- Memory contents are cleared to 0 by reset.
- `resetn` low at any time, including mid-`ACCESS`, forces `IDLE`, all outputs to 0, counter to 0, and memory to 0.
- A write in flight is lost.

**Hold rules**
- `prdata` holds its value after completion until the next read setup is captured.
- Write transfers leave `prdata` unchanged.

## Timing

**Zero wait (macro off, or `WAIT_CYCLES`=0)**
- Setup edge → first `ACCESS` cycle has `pready`=1.
- The transfer completes at the end of the second bus cycle.

**With N wait states**
- `pready`=0 for the first N `ACCESS` cycles and 1 in cycle N+1.
- Total transfer = N+2 cycles.

**Read data:** `prdata` is valid from the first `ACCESS` cycle onward. There is no combinational path from `paddr` to `prdata`.

**Write data:** the memory write becomes visible at the completion edge. A read whose setup edge follows that edge returns the new data.

**Back-to-back:** the minimum gap between transfers is one `IDLE` cycle, which matches the master's ACCESS→IDLE→SETUP sequence.

## Configuration

`APB_SLAVE_WAIT_EN`
- **Defined:** the wait counter is compiled in and each transfer inserts `WAIT_CYCLES` wait states.
- **Undefined:** no counter is built, `pready` = (state == `ACCESS`), and `WAIT_CYCLES` is ignored. Every transfer is zero-wait.

## Structure

**Shared package `apb_pkg`**
- `ADDR_WIDTH` and `DATA_WIDTH` defaults (10, 32), shared with `apb_master`.
- FSM state typedef or encoding: `IDLE`=0, `ACCESS`=1.
- Wait-counter width constant: 4.

**Sub-module `apb_slave_mem`**
- `MEM_DEPTH` × `DATA_WIDTH` array.
- Synchronous write port and registered read port.
- Async clear on `resetn`.
- `apb_slave` holds the FSM, capture registers, counter and error decode.

## Test plan

1. **Reset:** assert `resetn`=0 mid-idle → `prdata`=0, `pready`=0, `pslverr`=0. Then read addr 0x005 → 0x00000000.
2. **Write/read-back:** write 0xDEADBEEF to 0x010, then read 0x010 → `prdata`=0xDEADBEEF, `pslverr`=0, `pready` high for exactly one cycle per transfer.
3. **Wait states:** with `APB_SLAVE_WAIT_EN` and `WAIT_CYCLES`=2, read 0x010 → `pready` low for 2 `ACCESS` cycles, high on the 3rd, and 4 cycles setup-to-completion. With the macro undefined → `pready` high in the 1st `ACCESS` cycle.
4. **Out of range:** with `MEM_DEPTH`=256, write 0x12345678 to 0x100 → `pslverr`=1 with `pready`. Then read 0x100 → `prdata`=0, `pslverr`=1, and mem[0x000] is unchanged.
5. **Abort:** drop `pselx` in the first `ACCESS` cycle of a write of 0xA5A5A5A5 to 0x020 (`WAIT_CYCLES`=2) → FSM returns to `IDLE`, and a later read of 0x020 returns the old value.
6. **Reset mid-transfer:** pull `resetn` low during `ACCESS` of a write of 0xCAFEF00D to 0x030 → outputs 0 immediately (asynchronous), and after reset a read of 0x030 returns 0x00000000.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB segment (apb_master / apb_slave).
//   APB_ADDR_WIDTH  default paddr width in word-address units
//   APB_DATA_WIDTH  default pwdata/prdata width
//   APB_WAIT_CNT_W  width of the completer wait-state counter
//   apb_state_e     completer FSM encoding (IDLE=0, ACCESS=1)
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 10;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_WAIT_CNT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
// Word-addressed register memory behind apb_slave. Contents are flops so the
// whole array can be cleared by the asynchronous reset.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset (clears array)
//   we_i, waddr_i,
//   wdata_i            synchronous write port
//   re_i, raddr_i      read request; data is registered on the same edge
//   rdata_o            registered read data, holds between reads; an
//                      out-of-range read returns 0
// ---------------------------------------------------------------------------
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic w_in_range;
    logic r_in_range;

    // Addresses past MEM_DEPTH never touch the array, so the truncated
    // index below is only used when it is known to be valid.
    assign w_in_range = ({1'b0, waddr_i} < DEPTH_L);
    assign r_in_range = ({1'b0, raddr_i} < DEPTH_L);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && w_in_range) begin
            mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= r_in_range ? mem_q[raddr_i[IDX_W-1:0]] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
// APB completer backed by a word-addressed register memory.
// Optional feature macro: APB_SLAVE_WAIT_EN
//   defined   - a wait counter inserts WAIT_CYCLES wait states per transfer
//   undefined - every transfer is zero-wait, WAIT_CYCLES is ignored
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   pselx         completer select
//   penable       access-phase indicator
//   pwrite        1 = write, 0 = read
//   paddr         word address
//   pwdata        write data
//   prdata        read data, registered at the read setup edge
//   pready        transfer completes this cycle
//   pslverr       error response (address >= MEM_DEPTH), only with pready
//   dbg_state_o   current FSM state, for observation only
// ---------------------------------------------------------------------------
module apb_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output apb_state_e            dbg_state_o
);

    // Handshake: a transfer is offered by pselx=1/penable=0 for one cycle
    // (setup), then held with pselx=1/penable=1 (access). pready is the
    // completer's "done" strobe; a transfer completes on the rising edge where
    // pselx, penable and pready are all 1, and pslverr/prdata are only
    // meaningful in that cycle. Dropping pselx during access abandons it.

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q,   err_d;

    logic setup;
    logic addr_oor;
    logic cnt_zero;
    logic complete;
    logic mem_we;
    logic mem_re;

    assign setup    = (state_q == IDLE) && pselx && !penable;
    assign addr_oor = ({1'b0, paddr} >= DEPTH_L);

    // pready comes only from registered state, never from bus inputs.
    assign pready   = (state_q == ACCESS) && cnt_zero;
    assign pslverr  = pready && err_q;
    assign complete = pselx && penable && pready;

`ifdef APB_SLAVE_WAIT_EN
    localparam logic [APB_WAIT_CNT_W-1:0] WAIT_LOAD = APB_WAIT_CNT_W'(WAIT_CYCLES);

    logic [APB_WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (setup) begin
                cnt_d = WAIT_LOAD;
            end
        end else if (!pselx) begin
            cnt_d = '0;
        end else if ((cnt_q != '0) && penable) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;

    assign cnt_zero = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                // penable=1 without a preceding setup phase is ignored.
                if (setup) begin
                    state_d = ACCESS;
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    err_d   = addr_oor;
                end
            end
            ACCESS: begin
                if (!pselx || complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Read data is fetched at the setup edge, so prdata is already valid in
    // the first access cycle. Writes commit only on the completion edge.
    assign mem_re = setup && !pwrite;
    assign mem_we = (state_q == ACCESS) && complete && write_q && !err_q;

    apb_slave_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .resetn  (resetn),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .re_i    (mem_re),
        .raddr_i (paddr),
        .rdata_o (prdata)
    );

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_slave
// Scoreboard bench for apb_slave: the driver pushes the expected completion
// of each transfer into exp_q, and a negedge monitor pops and compares
// whenever a transfer completes on the bus.
// Expected entry packing: {err[36], wait_states[35:32], prdata[31:0]}.
// ---------------------------------------------------------------------------
module tb_apb_slave;
    import apb_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int EW    = 37;
`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic          clk;
    logic          resetn;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    apb_state_e    dbg_state;

    apb_slave #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_DEPTH   (DEPTH),
        .WAIT_CYCLES (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] last_rd;
    logic [EW-1:0] exp_q [$];
    int            n_checks;
    int            n_fail;
    bit            in_xfer;
    int            wait_cnt;
    bit            post_chk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        last_rd = '0;
        exp_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!resetn) begin
            wait_cnt = 0;
            post_chk = 1'b0;
        end else begin
            if (post_chk) begin
                chk("pready_one_cycle", 64'(pready), 64'(0));
                post_chk = 1'b0;
            end
            if (in_xfer && !pready) chk("pslverr_without_pready", 64'(pslverr), 64'(0));
            if (in_xfer && pselx && penable) begin
                if (pready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wait_states", 64'(wait_cnt), 64'(e[35:32]));
                        chk("pslverr", 64'(pslverr), 64'(e[36]));
                        chk("prdata", 64'(prdata), 64'(e[31:0]));
                    end
                    wait_cnt = 0;
                    post_chk = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [EW-1:0] e;
        logic          oor;
        logic [DW-1:0] exp_data;
        int            budget;
        bit            done;
        oor = (int'(a) >= DEPTH);
        if (wr) begin
            if (!oor) mem_m[a[7:0]] = d;
            exp_data = last_rd;
        end else begin
            exp_data = oor ? '0 : mem_m[a[7:0]];
            last_rd  = exp_data;
        end
        e = {oor, 4'(EXP_WAIT), exp_data};
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        pselx   = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        in_xfer = 1'b1;
        @(posedge clk);
        #1;
        penable = 1'b1;
        budget  = 0;
        done    = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (pready) begin
                done = 1'b1;
            end else begin
                budget++;
                if (budget > 40) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pready_timeout: got no pready expected pready within 40 cycles at %0t", $time);
                    void'(exp_q.pop_front());
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        pselx   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        in_xfer = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        in_xfer  = 1'b0;
        wait_cnt = 0;
        post_chk = 1'b0;
        pselx    = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        resetn   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("reset_prdata", 64'(prdata), 64'(0));
        chk("reset_pready", 64'(pready), 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(IDLE));

        // Reset while idle must clear prdata and memory.
        apb_xfer(1'b1, 10'h005, 32'h0000_0055);
        apb_xfer(1'b0, 10'h005, 32'h0);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("idle_reset_prdata", 64'(prdata), 64'(0));
        chk("idle_reset_pready", 64'(pready), 64'(0));
        chk("idle_reset_pslverr", 64'(pslverr), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        apb_xfer(1'b0, 10'h005, 32'h0);

        // Write / read-back, wait-state count checked on every completion.
        apb_xfer(1'b1, 10'h010, 32'hDEAD_BEEF);
        apb_xfer(1'b0, 10'h010, 32'h0);

        // Out-of-range write must be dropped, read returns 0 with error.
        apb_xfer(1'b1, 10'h000, 32'h1111_1111);
        apb_xfer(1'b1, 10'h100, 32'h1234_5678);
        apb_xfer(1'b0, 10'h100, 32'h0);
        apb_xfer(1'b0, 10'h000, 32'h0);
        apb_xfer(1'b0, 10'h0FF, 32'h0);
        apb_xfer(1'b0, 10'h3FF, 32'h0);

        // Abort: drop pselx in the first access cycle of a write.
        apb_xfer(1'b1, 10'h020, 32'h0BAD_CAFE);
        @(posedge clk);
        #1;
        pselx   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'h020;
        pwdata  = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        pselx   = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_state", 64'(dbg_state), 64'(IDLE));
        chk("abort_pready", 64'(pready), 64'(0));
        apb_xfer(1'b0, 10'h020, 32'h0);

        // Stray penable in IDLE without setup is ignored.
        @(posedge clk);
        #1;
        pselx   = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 10'h010;
        @(negedge clk);
        chk("stray_penable_pready", 64'(pready), 64'(0));
        @(negedge clk);
        chk("stray_penable_state", 64'(dbg_state), 64'(IDLE));
        #1;
        pselx   = 1'b0;
        penable = 1'b0;

        // Reset during the access phase of a write.
        @(posedge clk);
        #1;
        pselx   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 10'h030;
        pwdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        penable = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("midxfer_reset_prdata", 64'(prdata), 64'(0));
        chk("midxfer_reset_pready", 64'(pready), 64'(0));
        chk("midxfer_reset_pslverr", 64'(pslverr), 64'(0));
        chk("midxfer_reset_state", 64'(dbg_state), 64'(IDLE));
        pselx   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        apb_xfer(1'b0, 10'h030, 32'h0);
        apb_xfer(1'b0, 10'h010, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic          wr;
            logic [AW-1:0] a;
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(256, 1023));
            else                           a = AW'($urandom_range(0, 63));
            apb_xfer(wr, a, $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
